// File: rtl/ifetch_unit_if.sv
// ============================================================================
// Module      : ifetch_unit_if
// Description : Memory, instruction-register and control bundle of the
//               instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ifetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic              ir_ready;
    logic [ADDR_W-1:0] pc;
    logic              br_taken;
    logic [ADDR_W-1:0] br_addr;
    logic              halt;
    logic              fetch_err;

    // master: the fetch unit itself; slave: memory plus downstream ctrl
    modport master (
        output mem_req, mem_addr, ir, ir_valid, pc, fetch_err,
        input  mem_ack, mem_rdata, ir_ready, br_taken, br_addr, halt
    );

    modport slave (
        input  mem_req, mem_addr, ir, ir_valid, pc, fetch_err,
        output mem_ack, mem_rdata, ir_ready, br_taken, br_addr, halt
    );
endinterface

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch stage feeding the sisc core. Optional fetch
//               timeout is enabled with the IFETCH_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 255
) (
    input  wire logic     clk,
    input  wire logic     rst_f,
    ifetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        FULL   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              squash_q, squash_d;
    logic              timeout_hit;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("ifetch_unit: TIMEOUT must be at least 1");
    end

`ifdef IFETCH_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fetch_err_q, fetch_err_d;

    // Counter is zero outside REQ, so it is already clear on entry; an ack
    // restarts it for the follow-up request after a squash.
    always_comb begin
        wait_cnt_d  = '0;
        fetch_err_d = fetch_err_q;
        timeout_hit = 1'b0;
        if (state_q == REQ && !bus.mem_ack) begin
            wait_cnt_d  = wait_cnt_q + CNT_W'(1);
            timeout_hit = (wait_cnt_d == TIMEOUT_C);
        end
        if (timeout_hit) begin
            fetch_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            wait_cnt_q  <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign bus.fetch_err = fetch_err_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.fetch_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        squash_d   = squash_q;

        case (state_q)
            IDLE: begin
                if (bus.halt) begin
                    state_d = HALTED;
                end else begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                    if (bus.br_taken) begin
                        fetch_pc_d = bus.br_addr;
                        mem_addr_d = bus.br_addr;
                    end
                end
            end

            REQ: begin
                if (bus.mem_ack) begin
                    if (bus.halt) begin
                        state_d   = HALTED;
                        mem_req_d = 1'b0;
                        squash_d  = 1'b0;
                    end else if (bus.br_taken) begin
                        // Word arriving with the redirect is stale; refetch at target
                        fetch_pc_d = bus.br_addr;
                        mem_addr_d = bus.br_addr;
                        squash_d   = 1'b0;
                    end else if (squash_q) begin
                        squash_d   = 1'b0;
                        mem_addr_d = fetch_pc_q;
                    end else begin
                        state_d    = FULL;
                        ir_d       = bus.mem_rdata;
                        pc_d       = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                        ir_valid_d = 1'b1;
                        mem_req_d  = 1'b0;
                    end
                end else if (timeout_hit) begin
                    state_d    = HALTED;
                    mem_req_d  = 1'b0;
                    ir_valid_d = 1'b0;
                end else if (!bus.halt && bus.br_taken) begin
                    // Outstanding request must still complete; mem_addr held
                    fetch_pc_d = bus.br_addr;
                    squash_d   = 1'b1;
                end
            end

            FULL: begin
                if (bus.halt) begin
                    state_d    = HALTED;
                    ir_valid_d = 1'b0;
                    mem_req_d  = 1'b0;
                end else if (bus.br_taken) begin
                    state_d    = REQ;
                    fetch_pc_d = bus.br_addr;
                    ir_valid_d = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = bus.br_addr;
                end else if (bus.ir_ready) begin
                    state_d    = REQ;
                    ir_valid_d = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end

            default: begin
                state_d    = HALTED;
                ir_valid_d = 1'b0;
                mem_req_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            squash_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            squash_q   <= squash_d;
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.ir       = ir_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.pc       = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Self-checking bench for ifetch_unit: directed scenarios and a
//               randomized run against a transaction-level fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_unit;
    localparam int AW         = 16;
    localparam int DW         = 32;
    localparam int TB_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_f;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ifetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ifetch_unit #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RESET_PC (16'h0000),
        .TIMEOUT  (TB_TIMEOUT)
    ) u_dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    // Instruction memory image: a pure function of the word address
    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        return 32'h1000_0001 + {a, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic ack, input logic ready, input logic br,
                         input logic [AW-1:0] baddr, input logic hlt);
        bus.mem_ack   = ack;
        bus.mem_rdata = ack ? memval(bus.mem_addr) : '0;
        bus.ir_ready  = ready;
        bus.br_taken  = br;
        bus.br_addr   = baddr;
        bus.halt      = hlt;
        @(negedge clk);
    endtask

    // Memory answers any visible request immediately
    task automatic tick_auto(input logic ready);
        drive(bus.mem_req, ready, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst_f = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("rst_mem_req",   bus.mem_req,   0);
        check("rst_mem_addr",  bus.mem_addr,  0);
        check("rst_ir",        bus.ir,        0);
        check("rst_ir_valid",  bus.ir_valid,  0);
        check("rst_pc",        bus.pc,        0);
        check("rst_fetch_err", bus.fetch_err, 0);
        rst_f = 1'b0;
    endtask

    logic [AW-1:0] exp_next, p_pc, p_addr;
    logic [DW-1:0] p_ir;
    logic          p_valid, p_taken, p_req, p_ack;
    logic          r_ack, r_ready, r_br;
    logic [AW-1:0] r_baddr;
    int            deliveries, req_age;

    initial begin
        rst_f = 1'b1;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.ir_ready = 1'b0;
        bus.br_taken = 1'b0; bus.br_addr = '0; bus.halt = 1'b0;
        @(negedge clk);
        do_reset();

        // Sequential fetch with immediate acks
        tick_auto(1'b1);
        for (int k = 0; k < 3; k++) begin
            check("seq_req",  bus.mem_req,  1);
            check("seq_addr", bus.mem_addr, k);
            tick_auto(1'b1);
            check("seq_valid", bus.ir_valid, 1);
            check("seq_pc",    bus.pc,       k);
            check("seq_ir",    bus.ir,       memval(AW'(k)));
            check("seq_noreq", bus.mem_req,  0);
            if (k == 0) check("first_ir", bus.ir, 32'h1000_0001);
            if (k < 2) tick_auto(1'b1);
        end

        // Backpressure: ir/pc stable, no request
        for (int i = 0; i < 5; i++) begin
            tick_auto(1'b0);
            check("stall_valid", bus.ir_valid, 1);
            check("stall_pc",    bus.pc,       2);
            check("stall_ir",    bus.ir,       memval(16'd2));
            check("stall_req",   bus.mem_req,  0);
        end
        tick_auto(1'b1);
        check("resume_req",  bus.mem_req,  1);
        check("resume_addr", bus.mem_addr, 3);

        // Branch during REQ, ack delayed
        drive(1'b0, 1'b0, 1'b1, 16'h0040, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("sq_hold_req",   bus.mem_req,  1);
            check("sq_hold_addr",  bus.mem_addr, 3);
            check("sq_hold_valid", bus.ir_valid, 0);
            drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        check("sq_discard_valid", bus.ir_valid, 0);
        check("sq_retry_req",     bus.mem_req,  1);
        check("sq_retry_addr",    bus.mem_addr, 16'h0040);
        tick_auto(1'b0);
        check("br_tgt_valid", bus.ir_valid, 1);
        check("br_tgt_pc",    bus.pc,       16'h0040);
        check("br_tgt_ir",    bus.ir,       memval(16'h0040));

        // Branch and ready together in FULL
        drive(1'b0, 1'b1, 1'b1, 16'h0010, 1'b0);
        check("brfull_valid", bus.ir_valid, 0);
        check("brfull_req",   bus.mem_req,  1);
        check("brfull_addr",  bus.mem_addr, 16'h0010);
        tick_auto(1'b0);
        check("brfull_pc", bus.pc,       16'h0010);
        check("brfull_v",  bus.ir_valid, 1);

        // Address wrap at 16'hFFFF
        drive(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        check("wrap_addr0", bus.mem_addr, 16'hFFFF);
        tick_auto(1'b0);
        check("wrap_pc0", bus.pc, 16'hFFFF);
        tick_auto(1'b1);
        check("wrap_req",  bus.mem_req,  1);
        check("wrap_addr", bus.mem_addr, 16'h0000);
        tick_auto(1'b0);
        check("wrap_pc1", bus.pc, 16'h0000);
        check("wrap_ir1", bus.ir, memval(16'h0000));

        // Halt in FULL is permanent until reset
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("halt_req",   bus.mem_req,  0);
        check("halt_valid", bus.ir_valid, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b1, AW'($urandom), i[0]);
            check("halted_req",   bus.mem_req,  0);
            check("halted_valid", bus.ir_valid, 0);
        end
        do_reset();
        tick_auto(1'b0);
        check("post_rst_req",  bus.mem_req,  1);
        check("post_rst_addr", bus.mem_addr, 0);

        // Memory never acknowledges
`ifdef IFETCH_TIMEOUT_EN
        for (int i = 0; i < TB_TIMEOUT - 1; i++) drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("to_pre_err", bus.fetch_err, 0);
        check("to_pre_req", bus.mem_req,   1);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("to_err",   bus.fetch_err, 1);
        check("to_req",   bus.mem_req,   0);
        check("to_valid", bus.ir_valid,  0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 16'h0022, 1'b0);
        check("to_sticky_err", bus.fetch_err, 1);
        check("to_sticky_req", bus.mem_req,   0);
`else
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("wait_req",  bus.mem_req,   1);
        check("wait_addr", bus.mem_addr,  0);
        check("wait_err",  bus.fetch_err, 0);
`endif

        // Randomized run against a transaction-level model: the next delivered
        // instruction comes from the last branch target, else from consumed pc+1.
        do_reset();
        exp_next = 16'h0000;
        p_valid = 1'b0; p_taken = 1'b0; p_req = 1'b0; p_ack = 1'b0;
        p_pc = '0; p_addr = '0; p_ir = '0;
        deliveries = 0;
        req_age = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (p_req && !p_ack) begin
                check("rnd_hold_req",  bus.mem_req,  1);
                check("rnd_hold_addr", bus.mem_addr, p_addr);
            end
            if (p_valid && !p_taken) begin
                check("rnd_keep_valid", bus.ir_valid, 1);
                check("rnd_keep_pc",    bus.pc,       p_pc);
                check("rnd_keep_ir",    bus.ir,       p_ir);
            end else if (p_valid && p_taken) begin
                check("rnd_consumed", bus.ir_valid, 0);
            end else if (bus.ir_valid) begin
                check("rnd_pc", bus.pc, exp_next);
                check("rnd_ir", bus.ir, memval(bus.pc));
                deliveries++;
            end
            check("rnd_req_while_full", bus.ir_valid & bus.mem_req, 0);

            r_ack   = bus.mem_req && (($urandom_range(0, 2) == 0) || (req_age >= 2));
            r_ready = 1'($urandom_range(0, 1));
            r_br    = ($urandom_range(0, 15) == 0);
            r_baddr = AW'($urandom);

            if (r_br) exp_next = r_baddr;
            else if (bus.ir_valid && r_ready) exp_next = bus.pc + 16'd1;
            req_age = (bus.mem_req && !r_ack) ? req_age + 1 : 0;
            p_valid = bus.ir_valid;
            p_taken = r_br | r_ready;
            p_req   = bus.mem_req;
            p_ack   = r_ack;
            p_addr  = bus.mem_addr;
            p_pc    = bus.pc;
            p_ir    = bus.ir;

            drive(r_ack, r_ready, r_br, r_baddr, 1'b0);
        end
        check("rnd_progress", (deliveries > 100), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage directly upstream of the sisc core; produces the 32-bit ir that the core decodes.
- Holds the fetch program counter and issues word reads over a req/ack handshake to instruction memory.
- Latches the returned word into the instruction register and presents it to ctrl with a valid/ready handshake.
- Handles branch redirects, halt, and squashing of in-flight fetches.

Parameters:
ADDR_W, 16, width of program counter / instruction memory word address
DATA_W, 32, instruction width
RESET_PC, 0, fetch address loaded on reset
TIMEOUT, 255, max wait cycles for mem_ack (used only with IFETCH_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_f  in  1  reset, asynchronous, active-high
mem_req  out  1  instruction memory read request
mem_addr  out  ADDR_W  word address of request
mem_ack  in  1  memory returns mem_rdata this cycle
mem_rdata  in  DATA_W  instruction word, valid when mem_ack=1
ir  out  DATA_W  instruction register to sisc/ctrl
ir_valid  out  1  ir holds an unconsumed instruction
ir_ready  in  1  ctrl accepts ir this cycle
pc  out  ADDR_W  address of instruction currently in ir
br_taken  in  1  redirect fetch (1-cycle pulse from ctrl)
br_addr  in  ADDR_W  redirect target
halt  in  1  stop fetching (level)
fetch_err  out  1  sticky fetch timeout flag

Behaviour:
- Reset (async, rst_f=1): state=IDLE, fetch_pc=RESET_PC, pc=0, ir=0, ir_valid=0, mem_req=0, mem_addr=0, squash=0, fetch_err=0.
- States: IDLE, REQ, FULL, HALTED. All outputs are registered.
- IDLE: one cycle after reset release -> REQ.
- REQ:
  - mem_req=1, mem_addr=fetch_pc; both held stable until mem_ack.
  - On mem_ack with squash=0: ir<=mem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^ADDR_W, wraps to 0), ir_valid<=1, mem_req<=0 -> FULL.
  - On mem_ack with squash=1: discard data, squash<=0, mem_req stays 1 with mem_addr=fetch_pc (already the branch target); remain REQ.
  - Minimum latency: ack in the same cycle req is first seen -> ir_valid rises on the next edge.
- FULL:
  - ir and pc held, ir_valid=1.
  - ir_valid & ir_ready: ir_valid<=0, mem_req<=1 -> REQ.
- Branch: br_taken=1 sampled in any non-HALTED state loads fetch_pc<=br_addr.
  - In FULL: ir_valid<=0, -> REQ (instruction dropped even if ir_ready=1 in the same cycle).
  - In REQ without ack: request is not abandoned; squash<=1, mem_addr keeps the old address until ack.
  - In REQ with ack the same cycle: data discarded, mem_addr<=br_addr next cycle, stay REQ, squash stays 0.
  - Second br_taken while squash=1: latest br_addr wins.
- Halt: halt=1 sampled in IDLE/FULL -> HALTED with ir_valid<=0, mem_req<=0.
  - In REQ: the outstanding request completes (data discarded) -> HALTED.
  - HALTED is left only by reset; br_taken is ignored there.
- Priority, same cycle: reset > halt > br_taken > ir_ready/mem_ack.
- Reset asserted mid-request drops mem_req asynchronously; the memory must tolerate an abandoned request.

Optional Feature:
Macro IFETCH_TIMEOUT_EN.
- Defined:
  - 8-bit-or-wider wait counter clears on entering REQ and increments each REQ cycle without mem_ack.
  - When the counter reaches TIMEOUT without ack: fetch_err<=1 (sticky until reset), mem_req<=0, ir_valid<=0 -> HALTED.
  - Ack in the same cycle the count reaches TIMEOUT counts as success.
- Not defined: no counter; fetch_err tied to 0; REQ waits indefinitely.

Test Plan:
- Reset with RESET_PC=0, memory acks immediately, mem[0]=32'h1000_0001, ir_ready=1 -> mem_addr sequence 0,1,2; ir=32'h1000_0001 with pc=0, ir_valid high one cycle per fetch.
- ir_ready=0 for 5 cycles after the first fetch -> ir and pc stable, mem_req=0 throughout; ir_ready=1 -> mem_req=1, mem_addr=1 next cycle.
- br_taken with br_addr=16'h0040 during REQ, ack delayed 3 cycles -> mem_addr stays at the old address until ack, data discarded, next request mem_addr=16'h0040, ir_valid never rises for the squashed word.
- br_taken and ir_ready together in FULL, br_addr=16'h0010 -> ir_valid drops, next mem_addr=16'h0010, pc=16'h0010 after its ack.
- fetch_pc=16'hFFFF acked -> next mem_addr=0; halt=1 in FULL -> mem_req=0, ir_valid=0 permanently until rst_f pulse.
- With IFETCH_TIMEOUT_EN, TIMEOUT=4, mem_ack never asserts -> fetch_err=1 after 4 REQ cycles, mem_req=0, state HALTED; without the macro, mem_req stays 1 and fetch_err stays 0.
